// File: rtl/sync_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// sync_fifo_rd_stream
//
// Read-side consumer for the team synchronous FIFO. Issues fifo_rd_en, captures
// the registered rd_data one cycle later, and re-presents the words as a
// valid/ready stream through a 2-entry skid buffer (head/tail registers).
// Tracking the read that is still in flight lets the block keep one word per
// cycle moving under arbitrary back-pressure without dropping or duplicating.
//
// Optional feature macro: FIFO_RD_STAT_EN
//   defined   -> beat_cnt port present; counts accepted beats, saturating.
//   undefined -> beat_cnt port and counter logic are not built.
//
// Reset is synchronous and active-low (rst_n sampled on the rising clk edge).
// -----------------------------------------------------------------------------
module sync_fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO_RD_STAT_EN
  ,
  output logic [CNT_WIDTH-1:0]  beat_cnt
`endif
);

  // Buffer occupancy; 3 is unreachable and treated as an error state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e                  state_r;
  occ_e                  state_nxt_s;
  logic                  inflight_r;
  logic                  valid_r;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] tail_r;
  logic [DATA_WIDTH-1:0] head_nxt_s;
  logic [DATA_WIDTH-1:0] tail_nxt_s;
  logic                  pop_s;
  logic [2:0]            occ_sum_s;
  logic [1:0]            keep_cnt_s;
  logic                  rd_en_s;

  // A beat leaves the buffer when the sink accepts the registered head.
  assign pop_s = valid_r && m_ready;

  // Occupancy after this cycle's capture and pop, before any new issue lands.
  // The same sum both sets the next occupancy and gates the issue decision,
  // so a word is only requested when a slot is guaranteed for it.
  assign occ_sum_s = {1'b0, state_r} + {2'b00, inflight_r} - {2'b00, pop_s};

  // Words that survive the pop; the in-flight word lands right behind them.
  assign keep_cnt_s = state_r - {1'b0, pop_s};

  // Issue a read while the FIFO has data and a slot is still unclaimed.
  assign rd_en_s = !fifo_empty && rst_n && (occ_sum_s < 3'd2);

  assign fifo_rd_en = rd_en_s;
  assign m_valid    = valid_r;
  assign m_data     = head_r;

  // Next occupancy state from the capture/pop balance.
  always_comb begin
    state_nxt_s = state_r;
    case (occ_sum_s)
      3'd0:    state_nxt_s = EMPTY;
      3'd1:    state_nxt_s = ONE;
      3'd2:    state_nxt_s = TWO;
      default: state_nxt_s = TWO;
    endcase
  end

  // Skid-buffer datapath: shift on pop, then drop the returning word at the tail.
  always_comb begin
    head_nxt_s = head_r;
    tail_nxt_s = tail_r;
    if (pop_s) begin
      // Tail moves up; if the buffer held one word the head simply goes invalid.
      head_nxt_s = tail_r;
    end else begin
      head_nxt_s = head_r;
    end
    if (inflight_r) begin
      case (keep_cnt_s)
        2'd0:    head_nxt_s = fifo_rd_data;
        2'd1:    tail_nxt_s = fifo_rd_data;
        // A third word has nowhere to go; the issue rule prevents this.
        default: tail_nxt_s = tail_r;
      endcase
    end else begin
      tail_nxt_s = tail_nxt_s;
    end
  end

  // Occupancy state and in-flight tracking registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= EMPTY;
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      inflight_r <= rd_en_s;
    end
  end

  // Registered stream outputs: head word and its valid flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      head_r  <= {DATA_WIDTH{1'b0}};
      tail_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      valid_r <= (state_nxt_s != EMPTY);
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
    end
  end

`ifdef FIFO_RD_STAT_EN
  logic [CNT_WIDTH-1:0] beat_cnt_r;

  // Accepted-beat counter, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (pop_s && (beat_cnt_r != {CNT_WIDTH{1'b1}})) begin
      beat_cnt_r <= beat_cnt_r + CNT_WIDTH'(1);
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  assign beat_cnt = beat_cnt_r;
`else
  // Counter not built; the width parameter is kept so both builds share one
  // parameter list. An impossible width yields an empty, named marker scope.
  if (CNT_WIDTH < 1) begin : g_cnt_width_invalid
  end
`endif

  // Occupancy must never be asked to exceed two words.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    occ_sum_s <= 3'd2);

  // A capture into a full buffer without a pop would overwrite the tail.
  a_no_capture_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight_r && (state_r == TWO) && !pop_s));

  // The encoding value 3 is never a legal state.
  a_state_legal : assert property (@(posedge clk) disable iff (!rst_n)
    state_r != 2'd3);

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_rd_stream
//
// Directed bench: a behavioural FIFO (registered rd_data, one-cycle latency)
// feeds the DUT. A table of per-cycle vectors covers reset, a single word and
// back-to-back streaming; hand-written sequences cover back-pressure, a full
// stall and reset in the middle of a stream. Inputs change on the falling edge
// and outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_sync_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       fifo_empty;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
`ifdef FIFO_RD_STAT_EN
  logic [15:0] beat_cnt;
`endif

  sync_fifo_rd_stream dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready)
`ifdef FIFO_RD_STAT_EN
    ,
    .beat_cnt     (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural FIFO. 'hide' forces empty so words can be preloaded and then
  // released all at once.
  logic [7:0] mem [0:31];
  logic [4:0] wr_ptr;
  logic [4:0] rd_ptr;
  logic [5:0] count;
  logic       hide;
  logic       push_en;
  logic [7:0] push_data;
  logic       rd_ok;

  assign fifo_empty = (count == 6'd0) || hide;
  assign rd_ok      = fifo_rd_en && (count != 6'd0);

  always @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 5'd0;
      rd_ptr <= 5'd0;
      count  <= 6'd0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 5'd1;
      end
      if (rd_ok) begin
        fifo_rd_data <= mem[rd_ptr];
        rd_ptr       <= rd_ptr + 5'd1;
      end
      count <= count + {5'd0, push_en} - {5'd0, rd_ok};
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: apply inputs on the falling edge, settle, then caller samples.
  task automatic drive(input logic r, input logic rdy, input logic h,
                       input logic p, input logic [7:0] pd);
    @(negedge clk);
    rst_n     = r;
    m_ready   = rdy;
    hide      = h;
    push_en   = p;
    push_data = pd;
    #1;
  endtask

  // Queue eight consecutive words while they are hidden from the DUT.
  task automatic preload(input logic [7:0] base);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, base + 8'(k));
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic       m_ready;
    logic       hide;
    logic       push;
    logic [7:0] pdata;
    logic       exp_valid;
    logic       chk_data;
    logic [7:0] exp_data;
    logic       exp_rd_en;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rdy, input logic h,
                              input logic p, input logic [7:0] pd,
                              input logic ev, input logic cd,
                              input logic [7:0] ed, input logic er);
    vec_t v;
    v.rst_n = r; v.m_ready = rdy; v.hide = h; v.push = p; v.pdata = pd;
    v.exp_valid = ev; v.chk_data = cd; v.exp_data = ed; v.exp_rd_en = er;
    return v;
  endfunction

  vec_t vecs [28];

  initial begin
    int   got;
    int   issues;
    logic prev_stall;
    logic [7:0] prev_data;
    logic drop_chk;
    logic found;

    rst_n     = 1'b0;
    m_ready   = 1'b0;
    hide      = 1'b0;
    push_en   = 1'b0;
    push_data = 8'h00;

    // Reset held two cycles, then idle with an empty FIFO.
    vecs[0] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
    vecs[1] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
    vecs[2] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
    vecs[3] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
    // Single word 0xA5: read issued one cycle after it lands, valid two later.
    vecs[4] = mk(1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0);
    vecs[5] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1);
    vecs[6] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
    vecs[7] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0);
    vecs[8] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    // Preload 0x01..0x08 hidden, then stream with m_ready held high.
    for (int k = 0; k < 8; k++) begin
      vecs[9 + k] = mk(1'b1, 1'b1, 1'b1, 1'b1, 8'(k + 1), 1'b0, 1'b0, 8'h00, 1'b0);
    end
    vecs[17] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    vecs[18] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 6; k++) begin
      vecs[19 + k] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'(k + 1), 1'b1);
    end
    vecs[25] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h07, 1'b0);
    vecs[26] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h08, 1'b0);
    vecs[27] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].rst_n, vecs[i].m_ready, vecs[i].hide, vecs[i].push, vecs[i].pdata);
      check($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_rd_en", i), 32'(fifo_rd_en), 32'(vecs[i].exp_rd_en));
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d_data", i), 32'(m_data), 32'(vecs[i].exp_data));
      end
`ifdef FIFO_RD_STAT_EN
      if (i == 1) check("vec_beat_cnt_reset", 32'(beat_cnt), 32'd0);
      if (i == 8) check("vec_beat_cnt_single", 32'(beat_cnt), 32'd1);
`endif
    end
`ifdef FIFO_RD_STAT_EN
    check("beat_cnt_after_stream", 32'(beat_cnt), 32'd9);
`endif

    // Back-pressure: m_ready pattern 1,0,0 repeating.
    preload(8'h10);
    got        = 0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    for (int c = 0; c < 60; c++) begin
      drive(1'b1, (c % 3) == 0, 1'b0, 1'b0, 8'h00);
      if (prev_stall) begin
        check("bp_hold_valid", 32'(m_valid), 32'd1);
        check("bp_hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        check("bp_order", 32'(m_data), 32'h10 + 32'(got));
        got++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
    check("bp_count", 32'(got), 32'd8);
    check("bp_drained", 32'(m_valid), 32'd0);
`ifdef FIFO_RD_STAT_EN
    check("beat_cnt_after_bp", 32'(beat_cnt), 32'd17);
`endif

    // Stall full: only two reads may be outstanding with the sink stalled.
    preload(8'h30);
    issues = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      if (fifo_rd_en) issues++;
    end
    check("stall_issues", 32'(issues), 32'd2);
    check("stall_valid", 32'(m_valid), 32'd1);
    check("stall_data", 32'(m_data), 32'h30);
    got      = 0;
    drop_chk = 1'b0;
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      if (drop_chk) begin
        check("stall_valid_drop", 32'(m_valid), 32'd0);
        drop_chk = 1'b0;
      end else if (m_valid) begin
        check("stall_order", 32'(m_data), 32'h30 + 32'(got));
        got++;
        if (got == 8) drop_chk = 1'b1;
      end
    end
    check("stall_count", 32'(got), 32'd8);
`ifdef FIFO_RD_STAT_EN
    check("beat_cnt_after_stall", 32'(beat_cnt), 32'd25);
`endif

    // Reset mid-stream, right after an issued read.
    preload(8'h20);
    got   = 0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      if (m_valid) begin
        check("rst_pre_order", 32'(m_data), 32'h20 + 32'(got));
        got++;
      end
      if (got >= 3 && fifo_rd_en) found = 1'b1;
    end
    check("rst_found_issue", 32'(found), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("rst_rd_en_low", 32'(fifo_rd_en), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    check("rst_valid_clear", 32'(m_valid), 32'd0);
    check("rst_data_clear", 32'(m_data), 32'd0);
`ifdef FIFO_RD_STAT_EN
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
`endif
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      check("rst_no_stale", 32'(m_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
